// File: rtl/enduro_axis_pack.sv
// AXI4-Stream width upsizer: packs RATIO input beats of DATA_WIDTH bits into one wide
// output word with per-lane keep. A flush pulse closes a partially filled word early.
// All outputs are registered so the wide consumer never sees the upstream FIFO's
// combinational valid.
module enduro_axis_pack #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned RATIO      = 4
) (
  input  logic                          axis_clk,
  input  logic                          axis_areset,
  input  logic [DATA_WIDTH-1:0]         s_axis_tdata,
  input  logic                          s_axis_tvalid,
  output logic                          s_axis_tready,
  input  logic                          flush,
  output logic [DATA_WIDTH*RATIO-1:0]   m_axis_tdata,
  output logic [RATIO-1:0]              m_axis_tkeep,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic [$clog2(RATIO+1)-1:0]    lane_count
);

  localparam int unsigned CntW  = $clog2(RATIO + 1);
  localparam int unsigned WordW = DATA_WIDTH * RATIO;

  // Accumulator holds the word being assembled, or a complete word waiting on a busy output.
  logic [WordW-1:0] acc_data_q, acc_data_d;
  logic [RATIO-1:0] acc_keep_q, acc_keep_d;
  logic [CntW-1:0]  lane_cnt_q, lane_cnt_d;
  logic             acc_full_q, acc_full_d;
  logic             s_ready_q, s_ready_d;
  logic [WordW-1:0] m_data_q, m_data_d;
  logic [RATIO-1:0] m_keep_q, m_keep_d;
  logic             m_valid_q, m_valid_d;

  logic             accept;
  logic             drain;
  logic             out_free;
  logic             last_lane;
  logic             complete;
  logic [WordW-1:0] merged_data;
  logic [RATIO-1:0] merged_keep;

  // Accumulator contents with the beat accepted this cycle (if any) merged into its lane.
  always_comb begin
    accept      = s_axis_tvalid & s_ready_q;
    drain       = m_valid_q & m_axis_tready;
    out_free    = ~m_valid_q | m_axis_tready;
    merged_data = acc_data_q;
    merged_keep = acc_keep_q;
    for (int i = 0; i < int'(RATIO); i++) begin
      if (accept && (lane_cnt_q == CntW'(i))) begin
        merged_data[i*DATA_WIDTH +: DATA_WIDTH] = s_axis_tdata;
        merged_keep[i]                          = 1'b1;
      end
    end
    last_lane = (lane_cnt_q == CntW'(RATIO - 1));
    // A held full word ignores flush; s_ready_q is already low so no beat can arrive.
    complete  = ~acc_full_q &
                ((accept & last_lane) | (flush & ((lane_cnt_q != '0) | accept)));
  end

  // Next-state: drain a held word, hand off a completed word, or keep accumulating.
  always_comb begin
    acc_data_d = acc_data_q;
    acc_keep_d = acc_keep_q;
    lane_cnt_d = lane_cnt_q;
    acc_full_d = acc_full_q;
    m_data_d   = m_data_q;
    m_keep_d   = m_keep_q;
    m_valid_d  = m_valid_q & ~m_axis_tready;

    if (acc_full_q) begin
      if (drain) begin
        m_data_d   = acc_data_q;
        m_keep_d   = acc_keep_q;
        m_valid_d  = 1'b1;
        acc_data_d = '0;
        acc_keep_d = '0;
        lane_cnt_d = '0;
        acc_full_d = 1'b0;
      end
    end else if (complete) begin
      if (out_free) begin
        m_data_d   = merged_data;
        m_keep_d   = merged_keep;
        m_valid_d  = 1'b1;
        acc_data_d = '0;
        acc_keep_d = '0;
        lane_cnt_d = '0;
      end else begin
        // Output busy: park the finished word; lane_count keeps the beat count.
        acc_data_d = merged_data;
        acc_keep_d = merged_keep;
        lane_cnt_d = lane_cnt_q + CntW'(accept);
        acc_full_d = 1'b1;
      end
    end else if (accept) begin
      acc_data_d = merged_data;
      acc_keep_d = merged_keep;
      lane_cnt_d = lane_cnt_q + CntW'(1);
    end

    s_ready_d = ~acc_full_d;
  end

  // State registers; reset drops every output, including s_axis_tready, to zero.
  always_ff @(posedge axis_clk or posedge axis_areset) begin
    if (axis_areset) begin
      acc_data_q <= '0;
      acc_keep_q <= '0;
      lane_cnt_q <= '0;
      acc_full_q <= 1'b0;
      s_ready_q  <= 1'b0;
      m_data_q   <= '0;
      m_keep_q   <= '0;
      m_valid_q  <= 1'b0;
    end else begin
      acc_data_q <= acc_data_d;
      acc_keep_q <= acc_keep_d;
      lane_cnt_q <= lane_cnt_d;
      acc_full_q <= acc_full_d;
      s_ready_q  <= s_ready_d;
      m_data_q   <= m_data_d;
      m_keep_q   <= m_keep_d;
      m_valid_q  <= m_valid_d;
    end
  end

  assign s_axis_tready = s_ready_q;
  assign m_axis_tdata  = m_data_q;
  assign m_axis_tkeep  = m_keep_q;
  assign m_axis_tvalid = m_valid_q;
  assign lane_count    = lane_cnt_q;

endmodule

// File: tb/tb_enduro_axis_pack.sv
// Directed and randomized bench for enduro_axis_pack with 8-bit lanes, RATIO = 4.
module tb_enduro_axis_pack;

  localparam int unsigned DW = 8;
  localparam int unsigned R  = 4;

  logic          axis_clk = 1'b0;
  logic          axis_areset;
  logic [DW-1:0] s_axis_tdata;
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic          flush;
  logic [31:0]   m_axis_tdata;
  logic [3:0]    m_axis_tkeep;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic [2:0]    lane_count;

  enduro_axis_pack #(
    .DATA_WIDTH(DW),
    .RATIO     (R)
  ) dut (
    .axis_clk     (axis_clk),
    .axis_areset  (axis_areset),
    .s_axis_tdata (s_axis_tdata),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .flush        (flush),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tkeep (m_axis_tkeep),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .lane_count   (lane_count)
  );

  always #5 axis_clk = ~axis_clk;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic        v;
    logic [7:0]  d;
    logic        fl;
    logic        mr;
    logic        e_sr;
    logic        e_mv;
    logic [31:0] e_md;
    logic [3:0]  e_mk;
    logic [2:0]  e_lc;
  } vec_t;

  vec_t vecs[$];

  // Output words seen by the monitor, {keep, data}
  logic [35:0] got[$];
  logic [35:0] exp_q[$];
  logic        prev_stall = 1'b0;
  logic [35:0] prev_word;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge axis_clk);
    #1;
  endtask

  function automatic vec_t mk(logic v, logic [7:0] d, logic fl, logic mr, logic e_sr,
                              logic e_mv, logic [31:0] e_md, logic [3:0] e_mk,
                              logic [2:0] e_lc);
    vec_t t;
    t.v = v; t.d = d; t.fl = fl; t.mr = mr; t.e_sr = e_sr; t.e_mv = e_mv;
    t.e_md = e_md; t.e_mk = e_mk; t.e_lc = e_lc;
    return t;
  endfunction

  // One cycle of source drive; took reports whether the beat is accepted on this edge.
  task automatic send_cycle(input logic v, input logic [7:0] d, output logic took);
    s_axis_tvalid = v;
    s_axis_tdata  = d;
    took          = v & s_axis_tready;
    tick();
  endtask

  // Monitor: records output handshakes and checks hold-while-stalled, away from posedge.
  always @(negedge axis_clk) begin
    if (axis_areset) begin
      prev_stall <= 1'b0;
    end else begin
      if (prev_stall) begin
        chk("mvalid_hold", {63'd0, m_axis_tvalid}, 64'd1);
        chk("mword_hold", {28'd0, m_axis_tkeep, m_axis_tdata}, {28'd0, prev_word});
      end
      if (m_axis_tvalid && m_axis_tready) got.push_back({m_axis_tkeep, m_axis_tdata});
      prev_stall <= m_axis_tvalid & ~m_axis_tready;
      prev_word  <= {m_axis_tkeep, m_axis_tdata};
    end
  end

  initial begin
    logic       took;
    int         idx;
    int         cyc;
    logic [7:0] src[$];
    logic [7:0] b;
    logic [31:0] w;
    int         nacc;

    axis_areset   = 1'b1;
    s_axis_tdata  = '0;
    s_axis_tvalid = 1'b0;
    flush         = 1'b0;
    m_axis_tready = 1'b0;
    tick();
    tick();
    chk("rst_sready", {63'd0, s_axis_tready}, 64'd0);
    chk("rst_mvalid", {63'd0, m_axis_tvalid}, 64'd0);
    chk("rst_lane", {61'd0, lane_count}, 64'd0);
    axis_areset = 1'b0;
    #1;
    chk("rel_sready_pre", {63'd0, s_axis_tready}, 64'd0);
    tick();
    chk("rel_sready_post", {63'd0, s_axis_tready}, 64'd1);

    // Back-to-back full words, then partial words via flush
    vecs.push_back(mk(1, 8'h11, 0, 1, 1, 0, 32'h0, 4'h0, 3'd1));
    vecs.push_back(mk(1, 8'h22, 0, 1, 1, 0, 32'h0, 4'h0, 3'd2));
    vecs.push_back(mk(1, 8'h33, 0, 1, 1, 0, 32'h0, 4'h0, 3'd3));
    vecs.push_back(mk(1, 8'h44, 0, 1, 1, 1, 32'h44332211, 4'hF, 3'd0));
    vecs.push_back(mk(1, 8'h55, 0, 1, 1, 0, 32'h0, 4'h0, 3'd1));
    vecs.push_back(mk(1, 8'h66, 0, 1, 1, 0, 32'h0, 4'h0, 3'd2));
    vecs.push_back(mk(1, 8'h77, 0, 1, 1, 0, 32'h0, 4'h0, 3'd3));
    vecs.push_back(mk(1, 8'h88, 0, 1, 1, 1, 32'h88776655, 4'hF, 3'd0));
    vecs.push_back(mk(0, 8'h00, 0, 1, 1, 0, 32'h0, 4'h0, 3'd0));
    vecs.push_back(mk(1, 8'h0A, 0, 1, 1, 0, 32'h0, 4'h0, 3'd1));
    vecs.push_back(mk(1, 8'h0B, 0, 1, 1, 0, 32'h0, 4'h0, 3'd2));
    vecs.push_back(mk(1, 8'h0C, 0, 1, 1, 0, 32'h0, 4'h0, 3'd3));
    vecs.push_back(mk(0, 8'h00, 1, 1, 1, 1, 32'h000C0B0A, 4'h7, 3'd0));
    vecs.push_back(mk(0, 8'h00, 0, 1, 1, 0, 32'h0, 4'h0, 3'd0));
    vecs.push_back(mk(1, 8'h0D, 0, 1, 1, 0, 32'h0, 4'h0, 3'd1));
    vecs.push_back(mk(1, 8'h0E, 1, 1, 1, 1, 32'h00000E0D, 4'h3, 3'd0));
    vecs.push_back(mk(0, 8'h00, 0, 1, 1, 0, 32'h0, 4'h0, 3'd0));
    vecs.push_back(mk(0, 8'h00, 1, 1, 1, 0, 32'h0, 4'h0, 3'd0));
    vecs.push_back(mk(0, 8'h00, 0, 1, 1, 0, 32'h0, 4'h0, 3'd0));

    foreach (vecs[i]) begin
      s_axis_tvalid = vecs[i].v;
      s_axis_tdata  = vecs[i].d;
      flush         = vecs[i].fl;
      m_axis_tready = vecs[i].mr;
      tick();
      chk($sformatf("v%0d_sready", i), {63'd0, s_axis_tready}, {63'd0, vecs[i].e_sr});
      chk($sformatf("v%0d_mvalid", i), {63'd0, m_axis_tvalid}, {63'd0, vecs[i].e_mv});
      chk($sformatf("v%0d_lane", i), {61'd0, lane_count}, {61'd0, vecs[i].e_lc});
      if (vecs[i].e_mv) begin
        chk($sformatf("v%0d_mdata", i), {32'd0, m_axis_tdata}, {32'd0, vecs[i].e_md});
        chk($sformatf("v%0d_mkeep", i), {60'd0, m_axis_tkeep}, {60'd0, vecs[i].e_mk});
      end
    end
    s_axis_tvalid = 1'b0;
    flush         = 1'b0;

    // Backpressure: one word in the output register, one parked in the accumulator
    got.delete();
    m_axis_tready = 1'b0;
    for (int i = 1; i <= 12; i++) src.push_back(8'(i));
    idx = 0;
    for (int c = 0; c < 10; c++) begin
      send_cycle(1'b1, src[idx], took);
      if (took) idx++;
    end
    chk("bp_accepted", 64'(idx), 64'd8);
    chk("bp_sready", {63'd0, s_axis_tready}, 64'd0);
    chk("bp_mvalid", {63'd0, m_axis_tvalid}, 64'd1);
    chk("bp_mdata", {32'd0, m_axis_tdata}, 64'h04030201);
    chk("bp_lane", {61'd0, lane_count}, 64'd4);
    flush = 1'b1;
    send_cycle(1'b1, src[idx], took);
    flush = 1'b0;
    chk("bp_flush_ign_lane", {61'd0, lane_count}, 64'd4);
    chk("bp_flush_ign_sready", {63'd0, s_axis_tready}, 64'd0);
    chk("bp_flush_ign_mdata", {32'd0, m_axis_tdata}, 64'h04030201);
    m_axis_tready = 1'b1;
    send_cycle(1'b1, src[idx], took);
    if (took) idx++;
    chk("bp_drain_sready", {63'd0, s_axis_tready}, 64'd1);
    chk("bp_drain_mvalid", {63'd0, m_axis_tvalid}, 64'd1);
    chk("bp_drain_mdata", {32'd0, m_axis_tdata}, 64'h08070605);
    chk("bp_drain_lane", {61'd0, lane_count}, 64'd0);
    cyc = 0;
    while (idx < 12 && cyc < 50) begin
      send_cycle(1'b1, src[idx], took);
      if (took) idx++;
      cyc++;
    end
    s_axis_tvalid = 1'b0;
    cyc = 0;
    while (got.size() < 3 && cyc < 50) begin
      tick();
      cyc++;
    end
    chk("bp_words", 64'(got.size()), 64'd3);
    if (got.size() == 3) begin
      chk("bp_w0", {28'd0, got[0]}, {28'd0, 4'hF, 32'h04030201});
      chk("bp_w1", {28'd0, got[1]}, {28'd0, 4'hF, 32'h08070605});
      chk("bp_w2", {28'd0, got[2]}, {28'd0, 4'hF, 32'h0C0B0A09});
    end

    // Asynchronous reset with 2 beats held and a word pending on the output
    m_axis_tready = 1'b0;
    for (int i = 0; i < 6; i++) send_cycle(1'b1, 8'(8'h21 + i), took);
    s_axis_tvalid = 1'b0;
    chk("pre_rst_mvalid", {63'd0, m_axis_tvalid}, 64'd1);
    chk("pre_rst_lane", {61'd0, lane_count}, 64'd2);
    #2;
    axis_areset = 1'b1;
    #1;
    chk("arst_sready", {63'd0, s_axis_tready}, 64'd0);
    chk("arst_mvalid", {63'd0, m_axis_tvalid}, 64'd0);
    chk("arst_mdata", {32'd0, m_axis_tdata}, 64'd0);
    chk("arst_mkeep", {60'd0, m_axis_tkeep}, 64'd0);
    chk("arst_lane", {61'd0, lane_count}, 64'd0);
    tick();
    got.delete();
    axis_areset   = 1'b0;
    m_axis_tready = 1'b1;
    tick();
    chk("arst_rel_sready", {63'd0, s_axis_tready}, 64'd1);
    for (int i = 0; i < 4; i++) tick();
    chk("arst_no_word", 64'(got.size()), 64'd0);
    send_cycle(1'b1, 8'h31, took);
    flush = 1'b1;
    send_cycle(1'b1, 8'h32, took);
    flush = 1'b0;
    s_axis_tvalid = 1'b0;
    chk("arst_new_mvalid", {63'd0, m_axis_tvalid}, 64'd1);
    chk("arst_new_word", {28'd0, m_axis_tkeep, m_axis_tdata}, {28'd0, 4'h3, 32'h00003231});
    tick();

    // Random valid/ready: output stream must equal packed input stream
    got.delete();
    exp_q.delete();
    nacc = 0;
    w    = '0;
    b    = 8'($urandom);
    s_axis_tvalid = 1'b0;
    cyc = 0;
    while (nacc < 1000 && cyc < 20000) begin
      if (!s_axis_tvalid) begin
        s_axis_tvalid = 1'($urandom_range(0, 1));
      end
      m_axis_tready = 1'($urandom_range(0, 1));
      send_cycle(s_axis_tvalid, b, took);
      if (took) begin
        w[(nacc % 4)*8 +: 8] = b;
        nacc++;
        if (nacc % 4 == 0) exp_q.push_back({4'hF, w});
        b = 8'($urandom);
        s_axis_tvalid = 1'($urandom_range(0, 1));
      end
      cyc++;
    end
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b1;
    chk("rnd_beats", 64'(nacc), 64'd1000);
    cyc = 0;
    while (got.size() < exp_q.size() && cyc < 100) begin
      tick();
      cyc++;
    end
    chk("rnd_words", 64'(got.size()), 64'(exp_q.size()));
    foreach (exp_q[i]) begin
      if (i < got.size()) chk($sformatf("rnd_w%0d", i), {28'd0, got[i]}, {28'd0, exp_q[i]});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/enduro_axis_pack.md
Name: enduro_axis_pack

Overview:
- Single-clock AXI4-Stream width upsizer in the read clock domain, directly downstream of the FIFO AXI-Stream master port.
- Accepts DATA_WIDTH beats and packs RATIO consecutive beats into one DATA_WIDTH*RATIO output word, with per-lane keep.
- A flush pulse emits a partial word.
- Registered outputs isolate the FIFO's combinational m_axis_tvalid from the wide downstream consumer.

Parameters:
- DATA_WIDTH, 32, width of one input beat (one lane).
- RATIO, 4, input beats per output word; legal range 2..16.

Ports:
- axis_clk  input  1  single clock for the whole block.
- axis_areset  input  1  asynchronous, active-high reset.
- s_axis_tdata  input  DATA_WIDTH  input beat data.
- s_axis_tvalid  input  1  input beat valid.
- s_axis_tready  output  1  input ready, registered.
- flush  input  1  single-cycle request to emit the partially filled word.
- m_axis_tdata  output  DATA_WIDTH*RATIO  packed word; lane i = bits [i*DATA_WIDTH +: DATA_WIDTH].
- m_axis_tkeep  output  RATIO  bit i = 1 when lane i holds a real beat.
- m_axis_tvalid  output  1  output word valid, registered.
- m_axis_tready  input  1  downstream ready.
- lane_count  output  $clog2(RATIO+1)  number of beats held in the accumulator.

Behaviour:
- Reset: clock and reset are as already decided (one clock; asynchronous, active-high reset).
- While axis_areset is high, all outputs are 0, including s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tkeep and lane_count. The accumulator and acc_full are cleared.
- Reset mid-word discards all held beats without emitting them.
- s_axis_tready rises on the first axis_clk edge after reset release.
- Input beat accepted: s_axis_tvalid & s_axis_tready.
  - Beat k of a word (k = lane_count) is written to lane k, with keep bit k set, in the accumulator.
  - lane_count increments.
  - The first beat goes to the lowest lane.
- Word completion is either of:
  - acceptance of lane RATIO-1;
  - flush=1 with (lane_count>0 or a beat accepted in the same cycle). A beat accepted in the same cycle is included in the word.
- flush with lane_count==0 and no accepted beat is ignored.
- flush while acc_full=1 is ignored; the held word is already complete.
- Output register:
  - It is free when m_axis_tvalid==0, or when m_axis_tvalid & m_axis_tready in that cycle (drain).
  - On completion with the output register free, the word and keep load into m_axis_tdata/m_axis_tkeep, and m_axis_tvalid=1 on the next edge.
  - Latency is 1 cycle from the completing beat to m_axis_tvalid.
  - Unfilled lanes are zero; their keep bits are 0.
  - On completion with the output register not free, the word stays in the accumulator and acc_full=1.
  - While acc_full=1, s_axis_tready is driven 0 (registered).
- When acc_full=1 and the output drains:
  - The accumulator word loads into the output register on that edge.
  - acc_full clears.
  - The accumulator lanes and keep clear.
  - s_axis_tready returns to 1 on the same edge.
- s_axis_tready is a flop whose next value is ~acc_full_next. It never depends combinationally on m_axis_tready or s_axis_tvalid.
- With m_axis_tready held at 1, throughput is sustained at one input beat per cycle and one output word every RATIO cycles, with no bubbles.
- AXI rules:
  - m_axis_tvalid, once high, stays high with stable tdata/tkeep until it is accepted.
  - m_axis_tvalid falls after acceptance unless a new word loads on the same edge.
- lane_count:
  - Cleared to 0 on completion, or on the accumulator-to-output transfer when acc_full.
  - While acc_full=1, it reads RATIO for a full word, or the partial count for a flushed word.
- No data-dependent behaviour; tdata passes unmodified.

Test Plan:
- Reset then 8 back-to-back beats 0x11..0x88, m_axis_tready=1 -> two words:
  - 0x44332211 lanes (lane0=0x11), then 0x88776655;
  - tkeep=4'hF; m_axis_tvalid 1 cycle after beats 4 and 8; s_axis_tready stays 1.
- m_axis_tready=0, 12 beats offered -> first word held in the output register, second in the accumulator, acc_full=1, s_axis_tready=0 after beat 8, lane_count=4. Raise m_axis_tready -> words drain in order, s_axis_tready returns 1.
- 3 beats 0xA,0xB,0xC then flush -> one word with lanes 0xC,0xB,0xA in lanes 2..0, lane3=0, tkeep=4'h7, lane_count returns 0.
- flush in the same cycle as accepting beat 2 (0xE) after beat 1 (0xD) -> tkeep=4'h3, lanes 0xD,0xE. flush with lane_count=0 and no beat -> no output.
- axis_areset asserted asynchronously mid-cycle with 2 beats held and a word pending on the output -> all outputs 0 immediately, no word emitted after release, s_axis_tready=1 one edge after release.
- Randomized tvalid/tready at 50% for 1000 beats -> output words equal the packed input sequence. m_axis_tdata is stable while tvalid & ~tready.
